// File: rtl/mux_scan_sequencer_pkg.sv
// Shared constants and state encoding for the 8:1 mux scan sequencer.
package mux_scan_pkg;
  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;
endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Mux select/sample and word valid/ready signals between sequencer and its surroundings.
interface mux_scan_sequencer_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              mux_y;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic [NUM_CH-1:0] word;
  logic              valid;
  logic              ready;

  modport master (input start, mux_y, ready, output sel, busy, word, valid);
  modport slave  (output start, mux_y, ready, input sel, busy, word, valid);
endinterface

// File: rtl/mux_scan_sequencer_dwell_timer.sv
// Dwell counter: counts enabled cycles and flags the last cycle of each dwell window.
module scan_dwell_timer
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_count;

  assign o_done_c = i_en & (r_count == LAST);

  // Self-clearing on done so the next channel starts a fresh window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr || o_done_c) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 8:1 mux select, samples Y per channel after a dwell, and hands the
// assembled word to the consumer over valid/ready.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL      = 4,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_scan_sequencer_if.master bus
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic [NUM_CH-1:0] r_cap, w_cap_nxt;
  logic [NUM_CH-1:0] r_word, w_word_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_tmr_clr, w_tmr_en, w_done_c;
  logic [NUM_CH-1:0] w_cap_upd;

  scan_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_done_c (w_done_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_cap   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cap   <= w_cap_nxt;
      r_word  <= w_word_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cap_nxt   = r_cap;
    w_word_nxt  = r_word;
    w_valid_nxt = r_valid;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;
    w_cap_upd   = r_cap;
    w_cap_upd[r_sel] = bus.mux_y;

    case (r_state)
      IDLE: begin
        w_sel_nxt = '0;
        if (bus.start) begin
          w_state_nxt = SETTLE;
          w_tmr_clr   = 1'b1;
        end
      end
      SETTLE: begin
        w_tmr_en = 1'b1;
        if (w_done_c) begin
          w_cap_nxt = w_cap_upd;
          // Last channel goes straight to the output so valid lands on its sample edge.
          if (r_sel == LAST_CH) begin
            w_state_nxt = HOLD;
            w_word_nxt  = w_cap_upd;
            w_valid_nxt = 1'b1;
          end else begin
            w_sel_nxt = r_sel + SEL_W'(1);
          end
        end
      end
      HOLD: begin
        if (r_valid && bus.ready) begin
          w_valid_nxt = 1'b0;
          w_sel_nxt   = '0;
          if (CONTINUOUS) begin
            w_state_nxt = SETTLE;
            w_tmr_clr   = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_sel_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign bus.sel   = r_sel;
  assign bus.busy  = r_busy;
  assign bus.word  = r_word;
  assign bus.valid = r_valid;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed and randomized checks of the scan sequencer against a cycle-indexed sampling model.
module tb_mux_scan_sequencer;

  localparam int D0 = 4;
  localparam int D1 = 1;

  logic       clk;
  logic       rst_n;
  logic [7:0] in0;
  logic [7:0] in1;
  int         n_assert;
  int         n_fail;

  mux_scan_sequencer_if b0 ();
  mux_scan_sequencer_if b1 ();

  // 8:1 mux models feeding each sequencer
  assign b0.mux_y = in0[b0.sel];
  assign b1.mux_y = in1[b1.sel];

  mux_scan_sequencer #(.DWELL(D0), .CONTINUOUS(1'b0)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  mux_scan_sequencer #(.DWELL(D1), .CONTINUOUS(1'b1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle0(input string tag, input logic [7:0] word_exp);
    chk({tag, "_sel"},   32'(b0.sel),   32'(0));
    chk({tag, "_busy"},  32'(b0.busy),  32'(0));
    chk({tag, "_valid"}, 32'(b0.valid), 32'(0));
    chk({tag, "_word"},  32'(b0.word),  32'(word_exp));
  endtask

  // One scan on instance 0; expected bit n is the mux input driven for edge E+(n+1)*D0.
  task automatic scan0(input logic [7:0] pat, input bit rand_mid, input int bp,
                       input bit start_at_hs, input bit busy_starts);
    logic [7:0] exp;
    exp = 8'h00;
    in0 = pat;
    b0.start = 1'b1;
    step();
    b0.start = 1'b0;
    for (int k = 0; k < 8 * D0; k++) begin
      chk("scan_sel",   32'(b0.sel),   32'(k / D0));
      chk("scan_busy",  32'(b0.busy),  32'(1));
      chk("scan_valid", 32'(b0.valid), 32'(0));
      if (rand_mid) in0 = 8'($urandom);
      b0.ready = 1'($urandom);
      b0.start = busy_starts && (k == 5 || k == 20);
      if ((k + 1) % D0 == 0) exp[k / D0] = in0[k / D0];
      step();
    end
    b0.start = 1'b0;
    chk("done_valid", 32'(b0.valid), 32'(1));
    chk("done_word",  32'(b0.word),  32'(exp));
    chk("done_sel",   32'(b0.sel),   32'(7));
    chk("done_busy",  32'(b0.busy),  32'(1));
    for (int i = 0; i < bp; i++) begin
      b0.ready = 1'b0;
      in0 = 8'($urandom);
      step();
      chk("bp_valid", 32'(b0.valid), 32'(1));
      chk("bp_word",  32'(b0.word),  32'(exp));
      chk("bp_sel",   32'(b0.sel),   32'(7));
      chk("bp_busy",  32'(b0.busy),  32'(1));
    end
    b0.ready = 1'b1;
    b0.start = start_at_hs;
    step();
    b0.ready = 1'b0;
    b0.start = 1'b0;
    chk_idle0("hs", exp);
    step();
    chk_idle0("post_hs", exp);
  endtask

  // Continuous-mode scans on instance 1 (one cycle per channel).
  task automatic scan1(input int nscans);
    logic [7:0] exp;
    in1 = 8'h3C;
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    for (int s = 0; s < nscans; s++) begin
      exp = 8'h00;
      for (int k = 0; k < 8 * D1; k++) begin
        chk("cont_sel",   32'(b1.sel),   32'(k / D1));
        chk("cont_busy",  32'(b1.busy),  32'(1));
        chk("cont_valid", 32'(b1.valid), 32'(0));
        if (s >= 2) in1 = 8'($urandom);
        b1.ready = 1'($urandom);
        if ((k + 1) % D1 == 0) exp[k / D1] = in1[k / D1];
        step();
      end
      chk("cont_done_valid", 32'(b1.valid), 32'(1));
      chk("cont_done_word",  32'(b1.word),  32'(exp));
      chk("cont_done_sel",   32'(b1.sel),   32'(7));
      repeat (int'($urandom_range(0, 3))) begin
        b1.ready = 1'b0;
        step();
        chk("cont_bp_valid", 32'(b1.valid), 32'(1));
        chk("cont_bp_word",  32'(b1.word),  32'(exp));
      end
      b1.ready = 1'b1;
      in1 = (s == 0) ? 8'hC3 : 8'($urandom);
      step();
      b1.ready = 1'b0;
      chk("cont_hs_valid", 32'(b1.valid), 32'(0));
      chk("cont_hs_busy",  32'(b1.busy),  32'(1));
      chk("cont_hs_sel",   32'(b1.sel),   32'(0));
      chk("cont_hs_word",  32'(b1.word),  32'(exp));
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    b0.start = 1'b1;
    b1.start = 1'b1;
    b0.ready = 1'b1;
    b1.ready = 1'b1;
    in0 = 8'h00;
    in1 = 8'h00;

    // Reset held with start asserted and mux inputs toggling
    repeat (6) begin
      step();
      in0 = 8'($urandom);
      in1 = 8'($urandom);
      chk_idle0("rst", 8'h00);
      chk("rst1_sel",   32'(b1.sel),   32'(0));
      chk("rst1_busy",  32'(b1.busy),  32'(0));
      chk("rst1_valid", 32'(b1.valid), 32'(0));
      chk("rst1_word",  32'(b1.word),  32'(0));
    end
    rst_n    = 1'b1;
    b0.start = 1'b0;
    b1.start = 1'b0;
    b0.ready = 1'b0;
    b1.ready = 1'b0;
    repeat (4) begin
      step();
      chk_idle0("quiet", 8'h00);
      chk("quiet1_busy", 32'(b1.busy), 32'(0));
    end

    scan0(8'hA5, 1'b0, 0, 1'b0, 1'b0);
    scan0(8'h5A, 1'b0, 10, 1'b0, 1'b0);
    scan0(8'($urandom), 1'b0, 0, 1'b0, 1'b1);
    scan0(8'($urandom), 1'b0, 2, 1'b1, 1'b0);
    repeat (4) scan0(8'($urandom), 1'b1, int'($urandom_range(0, 5)), 1'($urandom), 1'($urandom));

    scan1(4);

    // Asynchronous reset in the middle of channel 3
    in0 = 8'($urandom);
    b0.start = 1'b1;
    step();
    b0.start = 1'b0;
    repeat (3 * D0) step();
    chk("mid_sel", 32'(b0.sel), 32'(3));
    #2 rst_n = 1'b0;
    #1 chk_idle0("async_rst", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_idle0("after_rst", 8'h00);
    scan0(8'hFF, 1'b0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
